timer_ctrl_4: RTL and testbench

4-bit programmable match timer controller. Holds a loaded target value, runs a 4-bit up-counter on qualified ticks, and uses the team's 4-bit equality comparator (comparator_4, data = target, count = count) to detect terminal count. Supports one-shot and periodic modes, start/stop control, and a 4-bit period counter. It sequences the comparator datapath for pulse and interval generation in the lab designs.

---
 rtl/timer_ctrl_4.sv | 108 ++++++++++
 tb/tb_timer_ctrl_4.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_4.sv
// 4-bit match timer: counts qualified ticks up to a loaded target, one-shot or periodic.
// All outputs registered; start->busy one cycle, terminal tick->match one cycle; no backpressure.

module comparator_4 (
  input  logic [3:0] data,
  input  logic [3:0] count,
  output logic       eq
);
  assign eq = (data == count);
endmodule

module timer_ctrl_4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] data_in,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic       tick,
  output logic       busy,
  output logic       match,
  output logic       done,
  output logic [3:0] count,
  output logic [3:0] target,
  output logic [3:0] periods
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] count_nxt, target_nxt, periods_nxt;
  logic       run_mode, run_mode_nxt;
  logic       match_nxt, done_nxt;
  logic       eq;

  comparator_4 u_cmp (
    .data  (target),
    .count (count),
    .eq    (eq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      target   <= 4'd0;
      periods  <= 4'd0;
      run_mode <= 1'b0;
      match    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      target   <= target_nxt;
      periods  <= periods_nxt;
      run_mode <= run_mode_nxt;
      match    <= match_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    target_nxt   = target;
    periods_nxt  = periods;
    run_mode_nxt = run_mode;
    match_nxt    = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (load)
          target_nxt = data_in;
        // stop overrides a simultaneous start
        if (start && !stop) begin
          state_nxt    = RUN;
          count_nxt    = 4'd0;
          periods_nxt  = 4'd0;
          run_mode_nxt = mode;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (!eq) begin
            count_nxt = count + 4'd1;
          end else begin
            match_nxt   = 1'b1;
            periods_nxt = periods + 4'd1;
            if (run_mode) begin
              count_nxt = 4'd0;
            end else begin
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_timer_ctrl_4.sv
// Directed bench for timer_ctrl_4; inputs driven and outputs sampled on the falling edge.
module tb_timer_ctrl_4;

  logic       clk = 1'b0;
  logic       reset, load, start, stop, mode, tick;
  logic [3:0] data_in;
  logic       busy, match, done;
  logic [3:0] count, target, periods;

  int vectors = 0;
  int miscompares = 0;

  timer_ctrl_4 dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .tick    (tick),
    .busy    (busy),
    .match   (match),
    .done    (done),
    .count   (count),
    .target  (target),
    .periods (periods)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL reset_match: got %0b expected 0", match); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (target !== 4'd0) begin miscompares++; $display("FAIL reset_target: got %0d expected 0", target); end
    vectors++; if (periods !== 4'd0) begin miscompares++; $display("FAIL reset_periods: got %0d expected 0", periods); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    load = 1'b1; data_in = 4'd5;
    @(negedge clk);
    load = 1'b0;
    vectors++; if (target !== 4'd5) begin miscompares++; $display("FAIL os_target: got %0d expected 5", target); end
    mode = 1'b0; tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL os_busy_start: got %0b expected 1", busy); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL os_count_start: got %0d expected 0", count); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      vectors++; if (count !== 4'(i)) begin miscompares++; $display("FAIL os_count_step%0d: got %0d expected %0d", i, count, i); end
      vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL os_early_match%0d: got %0b expected 0", i, match); end
    end
    @(negedge clk);
    vectors++; if (match !== 1'b1) begin miscompares++; $display("FAIL os_match: got %0b expected 1", match); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL os_done: got %0b expected 1", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL os_busy_done: got %0b expected 0", busy); end
    vectors++; if (periods !== 4'd1) begin miscompares++; $display("FAIL os_periods: got %0d expected 1", periods); end
    vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL os_count_done: got %0d expected 5", count); end
    @(negedge clk);
    vectors++; if (match !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL os_pulse_width: got match=%0b done=%0b expected 0 0", match, done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL os_busy_after: got %0b expected 0", busy); end
    vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL os_count_hold: got %0d expected 5", count); end
  endtask

  task automatic test_periodic();
    logic       exp_match;
    logic [3:0] exp_count, exp_periods;
    load = 1'b1; data_in = 4'd2;
    @(negedge clk);
    load = 1'b0;
    mode = 1'b1; tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 49; j++) begin
      if (j > 1) @(negedge clk);
      exp_match   = (j >= 4) && (((j - 1) % 3) == 0);
      exp_count   = 4'((j - 1) % 3);
      exp_periods = 4'(((j - 1) / 3) % 16);
      vectors++; if (match !== exp_match) begin miscompares++; $display("FAIL per_match_c%0d: got %0b expected %0b", j, match, exp_match); end
      vectors++; if (count !== exp_count) begin miscompares++; $display("FAIL per_count_c%0d: got %0d expected %0d", j, count, exp_count); end
      vectors++; if (periods !== exp_periods) begin miscompares++; $display("FAIL per_periods_c%0d: got %0d expected %0d", j, periods, exp_periods); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL per_busy_c%0d: got %0b expected 1", j, busy); end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL per_stop_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_slow_tick();
    logic [3:0] exp_count;
    load = 1'b1; data_in = 4'd3;
    @(negedge clk);
    load = 1'b0;
    mode = 1'b0; tick = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int m = 1; m <= 9; m++) begin
      exp_count = (m / 2 > 3) ? 4'd3 : 4'(m / 2);
      vectors++; if (count !== exp_count) begin miscompares++; $display("FAIL slow_count_c%0d: got %0d expected %0d", m, count, exp_count); end
      vectors++; if (match !== (m == 8)) begin miscompares++; $display("FAIL slow_match_c%0d: got %0b expected %0b", m, match, (m == 8)); end
      vectors++; if (done !== (m == 8)) begin miscompares++; $display("FAIL slow_done_c%0d: got %0b expected %0b", m, done, (m == 8)); end
      vectors++; if (busy !== (m < 8)) begin miscompares++; $display("FAIL slow_busy_c%0d: got %0b expected %0b", m, busy, (m < 8)); end
      tick = (m % 2 == 1);
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic test_zero_target();
    load = 1'b1; data_in = 4'd0;
    @(negedge clk);
    load = 1'b0;
    mode = 1'b0; tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || match !== 1'b0) begin miscompares++; $display("FAIL zero_first: got busy=%0b match=%0b expected 1 0", busy, match); end
    @(negedge clk);
    vectors++; if (match !== 1'b1 || done !== 1'b1) begin miscompares++; $display("FAIL zero_match: got match=%0b done=%0b expected 1 1", match, done); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL zero_count: got %0d expected 0", count); end
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_stop_busy: got %0b expected 0", busy); end
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_stop_busy2: got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; tick = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %0b expected 1", done); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_start_in_done_ignored: got %0b expected 0", busy); end
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || count !== 4'd0) begin miscompares++; $display("FAIL b2b_restart: got busy=%0b count=%0d expected 1 0", busy, count); end
    @(negedge clk);
    vectors++; if (match !== 1'b1) begin miscompares++; $display("FAIL b2b_match: got %0b expected 1", match); end
    @(negedge clk);
  endtask

  task automatic test_stop();
    load = 1'b1; data_in = 4'd4;
    @(negedge clk);
    load = 1'b0;
    mode = 1'b1; tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load = 1'b1; data_in = 4'd9;
    @(negedge clk);
    load = 1'b0;
    vectors++; if (target !== 4'd4) begin miscompares++; $display("FAIL run_load_ignored: got %0d expected 4", target); end
    repeat (3) @(negedge clk);
    vectors++; if (count !== 4'd4) begin miscompares++; $display("FAIL stop_pre_count: got %0d expected 4", count); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL stop_match: got %0b expected 0", match); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy: got %0b expected 0", busy); end
    vectors++; if (count !== 4'd4) begin miscompares++; $display("FAIL stop_count: got %0d expected 4", count); end
    vectors++; if (periods !== 4'd0) begin miscompares++; $display("FAIL stop_periods: got %0d expected 0", periods); end
  endtask

  task automatic test_reset_midrun();
    load = 1'b1; data_in = 4'd7;
    @(negedge clk);
    load = 1'b0;
    mode = 1'b0; tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (count !== 4'd3 || busy !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got count=%0d busy=%0b expected 3 1", count, busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL mid_count: got %0d expected 0", count); end
    vectors++; if (target !== 4'd0) begin miscompares++; $display("FAIL mid_target: got %0d expected 0", target); end
    vectors++; if (periods !== 4'd0) begin miscompares++; $display("FAIL mid_periods: got %0d expected 0", periods); end
    vectors++; if (busy !== 1'b0 || match !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_flags: got busy=%0b match=%0b done=%0b expected 0 0 0", busy, match, done); end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    mode = 1'b0; tick = 1'b0; data_in = 4'd0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_slow_tick();
    test_zero_target();
    test_back_to_back();
    test_stop();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
